// File: rtl/wb_retire_unit.sv
// wb_retire_unit: multi-lane registered writeback / retire stage.
// Retires up to LANES instructions per cycle in program order (lane 0 oldest),
// squashes everything from the oldest excepting lane upward, drops shadowed
// same-rd writes, holds a precise trap until trap_ack, and counts retirements.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   stall, flush                downstream stall / discard incoming group
//   in_valid, rd_in, reg_write_enable_in, writeback_data_in   per-lane group
//   exception_occurred_in, exception_pc_in, exception_cause_in per-lane trap info
//   trap_ack                    trap unit consumed the held exception
//   in_ready                    group accepted this cycle (when !flush)
//   regfile_rd/wd/we            registered register-file write port per lane
//   exception_out/pc_out/cause_out  held precise trap
//   instret_out                 64-bit retired instruction count (wraps)

// Per-lane write decision: a lane writes unless it is dead, targets x0, or a
// younger live lane in the same group overwrites the same register.
module wb_retire_lane #(
  parameter int K     = 0,
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]      live,
  input  logic [LANES-1:0]      wen,
  input  logic [LANES-1:0][4:0] rd,
  output logic                  wr
);
  always_comb begin
    wr = live[K] && wen[K] && (rd[K] != 5'd0);
    for (int j = K + 1; j < LANES; j++)
      if (live[j] && wen[j] && (rd[j] == rd[K])) wr = 1'b0;
  end
endmodule

module wb_retire_unit #(
  parameter int XLEN    = 64,
  parameter int LANES   = 2,
  parameter int CAUSE_W = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         in_valid,
  input  logic [5*LANES-1:0]       rd_in,
  input  logic [LANES-1:0]         reg_write_enable_in,
  input  logic [XLEN*LANES-1:0]    writeback_data_in,
  input  logic [LANES-1:0]         exception_occurred_in,
  input  logic [XLEN*LANES-1:0]    exception_pc_in,
  input  logic [CAUSE_W*LANES-1:0] exception_cause_in,
  input  logic                     trap_ack,
  output logic                     in_ready,
  output logic [5*LANES-1:0]       regfile_rd,
  output logic [XLEN*LANES-1:0]    regfile_wd,
  output logic [LANES-1:0]         regfile_we,
  output logic                     exception_out,
  output logic [XLEN-1:0]          exception_pc_out,
  output logic [CAUSE_W-1:0]       exception_cause_out,
  output logic [63:0]              instret_out
);
  typedef enum logic {IDLE, TRAP} state_t;
  state_t state_q, state_d;

  // Packed views: lane k sits at the k-th slice of each flat bus.
  logic [LANES-1:0][4:0]         rd_arr;
  logic [LANES-1:0][XLEN-1:0]    pc_arr;
  logic [LANES-1:0][CAUSE_W-1:0] cause_arr;
  assign rd_arr    = rd_in;
  assign pc_arr    = exception_pc_in;
  assign cause_arr = exception_cause_in;

  logic [LANES-1:0] exc_v, squash, live, wr;
  logic             has_exc, accept;
  logic [XLEN-1:0]    sel_pc;
  logic [CAUSE_W-1:0] sel_cause;
  logic [63:0]        n_ret;

  assign exc_v   = in_valid & exception_occurred_in;
  assign has_exc = |exc_v;
  assign live    = in_valid & ~squash;

  assign in_ready = resetn && (state_q == IDLE) && !stall;
  assign accept   = in_ready && !flush;

  // Squash mask is a prefix-OR of valid exceptions from lane 0 upward.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    squash = '0;
    for (int k = 0; k < LANES; k++) begin
      seen      = seen | exc_v[k];
      squash[k] = seen;
    end
  end

  // Scan high-to-low so the oldest excepting lane is the last assignment.
  always_comb begin
    sel_pc    = '0;
    sel_cause = '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (exc_v[k]) begin
        sel_pc    = pc_arr[k];
        sel_cause = cause_arr[k];
      end
  end

  // Every live lane retires, with or without a register write.
  always_comb begin
    n_ret = '0;
    for (int k = 0; k < LANES; k++) n_ret = n_ret + 64'(live[k]);
  end

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    wb_retire_lane #(.K(g), .LANES(LANES)) u_lane (
      .live (live),
      .wen  (reg_write_enable_in),
      .rd   (rd_arr),
      .wr   (wr[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && has_exc) state_d = TRAP;
      TRAP:    if (trap_ack)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q             <= IDLE;
      regfile_rd          <= '0;
      regfile_wd          <= '0;
      regfile_we          <= '0;
      exception_out       <= 1'b0;
      exception_pc_out    <= '0;
      exception_cause_out <= '0;
      instret_out         <= '0;
    end else begin
      state_q <= state_d;
      // Non-accepting cycles load a bubble.
      regfile_we <= accept ? wr                : '0;
      regfile_rd <= accept ? rd_in             : '0;
      regfile_wd <= accept ? writeback_data_in : '0;
      if (accept) instret_out <= instret_out + n_ret;
      if (accept && has_exc) begin
        exception_out       <= 1'b1;
        exception_pc_out    <= sel_pc;
        exception_cause_out <= sel_cause;
      end else if (state_q == TRAP && trap_ack) begin
        exception_out       <= 1'b0;
        exception_pc_out    <= '0;
        exception_cause_out <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;
  localparam int XL = 64, L = 2, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn, stall, flush, trap_ack;
  logic [L-1:0]      in_valid, rwe, exc;
  logic [5*L-1:0]    rd_in;
  logic [XL*L-1:0]   wd_in, pc_in;
  logic [CW*L-1:0]   cause_in;
  logic              in_ready, exception_out;
  logic [5*L-1:0]    regfile_rd;
  logic [XL*L-1:0]   regfile_wd;
  logic [L-1:0]      regfile_we;
  logic [XL-1:0]     exception_pc_out;
  logic [CW-1:0]     exception_cause_out;
  logic [63:0]       instret_out;

  wb_retire_unit #(.XLEN(XL), .LANES(L), .CAUSE_W(CW)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .in_valid(in_valid), .rd_in(rd_in), .reg_write_enable_in(rwe),
    .writeback_data_in(wd_in), .exception_occurred_in(exc),
    .exception_pc_in(pc_in), .exception_cause_in(cause_in),
    .trap_ack(trap_ack), .in_ready(in_ready), .regfile_rd(regfile_rd),
    .regfile_wd(regfile_wd), .regfile_we(regfile_we),
    .exception_out(exception_out), .exception_pc_out(exception_pc_out),
    .exception_cause_out(exception_cause_out), .instret_out(instret_out)
  );

  int nvec = 0, nchk = 0, nerr = 0;
  bit started = 0;

  // Reference model state: what the outputs must be after the last edge.
  logic            m_trap;
  logic [XL-1:0]   m_pc;
  logic [CW-1:0]   m_cause;
  logic [63:0]     m_instret;
  logic [L-1:0]    m_we;
  logic [5*L-1:0]  m_rd;
  logic [XL*L-1:0] m_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("we", 64'(regfile_we), 64'(m_we));
    chk("rd", 64'(regfile_rd), 64'(m_rd));
    chk("wd_lo", regfile_wd[63:0], m_wd[63:0]);
    chk("wd_hi", regfile_wd[127:64], m_wd[127:64]);
    chk("exc_out", 64'(exception_out), 64'(m_trap));
    chk("exc_pc", exception_pc_out, m_pc);
    chk("exc_cause", 64'(exception_cause_out), 64'(m_cause));
    chk("instret", instret_out, m_instret);
  end

  // One cycle: inputs already set; check in_ready, predict, cross the edge.
  task automatic cyc();
    logic            n_trap;
    logic [XL-1:0]   n_pc;
    logic [CW-1:0]   n_cause;
    logic [63:0]     n_instret;
    logic [L-1:0]    n_we;
    logic [5*L-1:0]  n_rd;
    logic [XL*L-1:0] n_wd;
    int owner [32];
    int e, rdk;
    #1;
    chk("in_ready", 64'(in_ready), 64'(resetn && !m_trap && !stall));
    n_trap = m_trap; n_pc = m_pc; n_cause = m_cause; n_instret = m_instret;
    n_we = '0; n_rd = '0; n_wd = '0;
    if (!resetn) begin
      n_trap = 0; n_pc = '0; n_cause = '0; n_instret = '0;
    end else if (m_trap) begin
      if (trap_ack) begin n_trap = 0; n_pc = '0; n_cause = '0; end
    end else if (!stall && !flush) begin
      n_rd = rd_in; n_wd = wd_in;
      e = L;
      for (int k = L - 1; k >= 0; k--) if (in_valid[k] && exc[k]) e = k;
      // Last writer in program order owns each register.
      for (int r = 0; r < 32; r++) owner[r] = -1;
      for (int k = 0; k < e; k++)
        if (in_valid[k]) begin
          n_instret = n_instret + 1;
          rdk = int'(rd_in[5*k +: 5]);
          if (rwe[k] && rdk != 0) owner[rdk] = k;
        end
      for (int k = 0; k < e; k++)
        if (owner[int'(rd_in[5*k +: 5])] == k) n_we[k] = 1'b1;
      if (e < L) begin
        n_trap = 1; n_pc = pc_in[XL*e +: XL]; n_cause = cause_in[CW*e +: CW];
      end
    end
    @(posedge clk);
    m_trap = n_trap; m_pc = n_pc; m_cause = n_cause; m_instret = n_instret;
    m_we = n_we; m_rd = n_rd; m_wd = n_wd;
    started = 1; nvec++;
    @(negedge clk);
  endtask

  task automatic grp(input logic [1:0] v, input logic [1:0] we,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic [63:0] w0, input logic [63:0] w1,
                     input logic [1:0] ex, input logic [63:0] p0,
                     input logic [63:0] p1, input logic [3:0] c0, input logic [3:0] c1);
    in_valid = v; rwe = we; rd_in = {r1, r0}; wd_in = {w1, w0};
    exc = ex; pc_in = {p1, p0}; cause_in = {c1, c0};
  endtask

  task automatic quiet();
    stall = 0; flush = 0; trap_ack = 0;
    grp(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    m_trap = 0; m_pc = '0; m_cause = '0; m_instret = '0; m_we = '0; m_rd = '0; m_wd = '0;
    resetn = 0; quiet();
    @(negedge clk);
    // Reset with everything active.
    trap_ack = 1;
    grp(2'b11, 2'b11, 5, 6, 64'h11, 64'h22, 2'b11, 64'h40, 64'h44, 3, 4);
    repeat (3) cyc();
    chk("rst_we", 64'(regfile_we), 64'd0);
    chk("rst_instret", instret_out, 64'd0);
    chk("rst_exc", 64'(exception_out), 64'd0);
    resetn = 1; quiet();
    #1 chk("rel_ready", 64'(in_ready), 64'd1);
    cyc();
    // Dual retire.
    grp(2'b11, 2'b11, 5, 6, 64'hAA, 64'hBB, 2'b00, 0, 0, 0, 0); cyc();
    chk("dual_we", 64'(regfile_we), 64'h3);
    chk("dual_rd", 64'(regfile_rd), 64'({5'd6, 5'd5}));
    chk("dual_wd1", regfile_wd[127:64], 64'hBB);
    chk("dual_instret", instret_out, 64'd2);
    // Same-rd conflict, then x0.
    grp(2'b11, 2'b11, 7, 7, 64'h1, 64'h2, 2'b00, 0, 0, 0, 0); cyc();
    chk("conf_we", 64'(regfile_we), 64'h2);
    chk("conf_instret", instret_out, 64'd4);
    grp(2'b01, 2'b01, 0, 0, 64'h9, 0, 2'b00, 0, 0, 0, 0); cyc();
    chk("x0_we", 64'(regfile_we), 64'h0);
    chk("x0_instret", instret_out, 64'd5);
    // Lane-0 exception, held 4 cycles through flush pulses.
    grp(2'b11, 2'b11, 1, 2, 64'h5, 64'h6, 2'b01, 64'h1000, 64'h1004, 2, 5); cyc();
    chk("e0_we", 64'(regfile_we), 64'h0);
    chk("e0_out", 64'(exception_out), 64'd1);
    chk("e0_pc", exception_pc_out, 64'h1000);
    chk("e0_cause", 64'(exception_cause_out), 64'd2);
    chk("e0_instret", instret_out, 64'd5);
    for (int i = 0; i < 4; i++) begin
      flush = i[0];
      grp(2'b11, 2'b11, 3, 4, 64'h7, 64'h8, 2'b10, 64'h3000, 64'h3004, 9, 9);
      cyc();
      chk("hold_pc", exception_pc_out, 64'h1000);
      chk("hold_out", 64'(exception_out), 64'd1);
    end
    quiet(); trap_ack = 1; cyc();
    chk("ack_out", 64'(exception_out), 64'd0);
    quiet(); cyc();
    // Lane-1 exception.
    grp(2'b11, 2'b11, 3, 4, 64'h33, 64'h44, 2'b10, 64'h2000, 64'h2004, 1, 6); cyc();
    chk("e1_we", 64'(regfile_we), 64'h1);
    chk("e1_instret", instret_out, 64'd6);
    chk("e1_pc", exception_pc_out, 64'h2004);
    quiet(); trap_ack = 1; cyc();
    // Stall, flush, stall+flush.
    quiet(); stall = 1; grp(2'b11, 2'b11, 8, 9, 1, 2, 0, 0, 0, 0, 0); cyc();
    chk("stall_we", 64'(regfile_we), 64'h0);
    chk("stall_instret", instret_out, 64'd6);
    stall = 0; flush = 1; cyc();
    chk("flush_we", 64'(regfile_we), 64'h0);
    stall = 1; cyc();
    chk("sf_instret", instret_out, 64'd6);
    // Reset during trap.
    quiet(); grp(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 64'h5000, 0, 7, 0); cyc();
    quiet(); resetn = 0; cyc();
    chk("rst_trap", 64'(exception_out), 64'd0);
    resetn = 1; cyc();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      resetn   = ($urandom_range(0, 63) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      trap_ack = ($urandom_range(0, 2) == 0);
      in_valid = 2'($urandom);
      rwe      = 2'($urandom);
      exc      = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      rd_in    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd_in    = {$urandom, $urandom, $urandom, $urandom};
      pc_in    = {$urandom, $urandom, $urandom, $urandom};
      cause_in = 8'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_retire_unit.md
Name: wb_retire_unit

Overview:
- Multi-lane, registered successor to the single-lane combinational writeback stage. Sits between memory stage and register file/trap logic.
- Retires up to LANES instructions per cycle in program order (lane 0 oldest). Resolves intra-group exceptions and same-rd write conflicts.
- Holds a precise trap until the CSR/trap unit acknowledges it, and maintains a 64-bit retired-instruction counter.

Parameters:
- XLEN, 64, data/PC width.
- LANES, 2, retire lanes per cycle (1..4).
- CAUSE_W, 4, exception cause width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- stall  in  1  downstream stall; no retire this cycle.
- flush  in  1  discard incoming group.
- in_valid  in  LANES  per-lane valid.
- rd_in  in  5*LANES  destination register per lane (lane k at [5k+4:5k]).
- reg_write_enable_in  in  LANES  per-lane write request.
- writeback_data_in  in  XLEN*LANES  per-lane write data.
- exception_occurred_in  in  LANES  per-lane exception flag.
- exception_pc_in  in  XLEN*LANES  per-lane PC.
- exception_cause_in  in  CAUSE_W*LANES  per-lane cause.
- trap_ack  in  1  trap unit has consumed the held exception.
- in_ready  out  1  group accepted this cycle.
- regfile_rd  out  5*LANES  registered write address.
- regfile_wd  out  XLEN*LANES  registered write data.
- regfile_we  out  LANES  registered write enable.
- exception_out  out  1  trap held.
- exception_pc_out  out  XLEN  PC of the trapping instruction.
- exception_cause_out  out  CAUSE_W  cause of the trap.
- instret_out  out  64  retired instruction count.

Behaviour:
- Reset (resetn=0 at posedge): all outputs zero, state IDLE. in_ready is 0 while resetn=0. Reset mid-trap drops the trap.
- in_ready = resetn && state==IDLE && !stall. The group is accepted when in_ready && !flush.
- Latency: an accepted group appears on regfile_* at the next posedge (1 cycle). In every non-accepting cycle the output register loads a bubble: regfile_we=0, rd/wd=0.
- Exception ordering: let e = lowest lane with in_valid && exception_occurred_in.
  - Lane e and all lanes above e are squashed: no write, not counted.
  - Lanes below e retire normally.
- Lane k writes iff all of the following hold:
  - in_valid[k] and reg_write_enable_in[k];
  - lane k is not squashed;
  - rd_in[k] != 0;
  - no younger unsquashed lane j>k writes the same rd.
- instret_out += count of valid, unsquashed lanes in the accepted group, including lanes without a register write. The counter wraps modulo 2^64.
- FSM:
  - IDLE: an accepted group with an exception latches exception_pc/cause of lane e, sets exception_out=1 next cycle, and moves to TRAP.
  - TRAP: exception_out/pc/cause are held stable, in_ready=0, and inputs are ignored. On trap_ack, the next cycle returns to IDLE with exception_out=0 and pc/cause cleared.
  - trap_ack in IDLE is ignored.
- flush in TRAP does not cancel the trap; only trap_ack or reset does.
- stall and flush together: nothing is accepted and a bubble is output.
- Outputs are registered only; there is no combinational path from in_* to regfile_*.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with all inputs active -> all outputs 0, instret_out=0, in_ready=0. Release -> in_ready=1.
- Dual retire (LANES=2): lane0 rd=5 wd=0xAA, lane1 rd=6 wd=0xBB, both we=1 -> the next cycle regfile_we=2'b11 with matching rd/wd; instret_out=2.
- Same-rd conflict plus x0: lane0 rd=7 wd=1, lane1 rd=7 wd=2 -> we=2'b10. Then lane0 rd=0 we=1 -> we[0]=0 while instret still increments.
- Lane-0 exception: exc=2'b01, pc0=0x1000, cause=2 -> we=2'b00, exception_out=1, pc=0x1000, cause=2, in_ready=0, instret unchanged. Hold 4 cycles with flush pulsed -> outputs stable. trap_ack -> next cycle exception_out=0, in_ready=1.
- Lane-1 exception: lane0 rd=3 we=1, exc=2'b10, pc1=0x2004 -> we=2'b01, instret+1, exception_pc_out=0x2004.
- Stall/flush: stall=1 with a valid group -> we=0, instret unchanged, in_ready=0. flush=1, stall=0 -> bubble, instret unchanged. Reset asserted during TRAP -> exception_out=0 after that posedge.
